// File: rtl/wb_pkg.sv
// wb_pkg: shared writeback-queue types, widths and pointer helper.
//   WB_DATA_W  - default result width
//   WB_ADDR_W  - default register-number width
//   wb_entry_t - one queued result {rd, data}
//   wb_ptr_inc - wrap-around pointer increment
package wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 5;

    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    function automatic int wb_ptr_inc(input int ptr, input int depth);
        return (ptr + 1) % depth;
    endfunction

endpackage

// File: rtl/wb_match.sv
// wb_match: DEPTH-way youngest-first forwarding comparator over the queue entries.
//   rd_i, data_i - entry storage, indexed by slot
//   valid_i      - per-slot occupancy mask
//   head_i       - slot of the oldest entry
//   lookup_i     - register number to look up (0 never hits)
//   hit_o        - some valid entry targets lookup_i
//   data_o       - data of the youngest matching entry, 0 when no hit
module wb_match
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W,
    parameter int PW     = $clog2(DEPTH)
) (
    input  logic [ADDR_W-1:0] rd_i   [DEPTH],
    input  logic [DATA_W-1:0] data_i [DEPTH],
    input  logic [DEPTH-1:0]  valid_i,
    input  logic [PW-1:0]     head_i,
    input  logic [ADDR_W-1:0] lookup_i,
    output logic              hit_o,
    output logic [DATA_W-1:0] data_o
);

    logic [PW-1:0] slot;

    // Walk oldest to youngest; a later match overwrites an earlier one so the
    // youngest entry wins. Slot wrap comes free from PW-bit truncation.
    always_comb begin
        hit_o  = 1'b0;
        data_o = '0;
        slot   = head_i;
        for (int k = 0; k < DEPTH; k++) begin
            slot = head_i + PW'(k);
            if (valid_i[slot] && rd_i[slot] == lookup_i && lookup_i != '0) begin
                hit_o  = 1'b1;
                data_o = data_i[slot];
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// wb_queue: in-order writeback queue feeding the register-file write port,
// with forwarding lookups over entries not yet written.
//   clock, reset                - clock, synchronous active-high reset
//   in_valid/in_ready           - result handshake; in_rd/in_data carry the result
//   drain_en                    - allow the head entry to be written this cycle
//   rf_regwrite/rf_write_reg/rf_write_data - register-file write port
//   lookup_rs1/2, hit1/2, fwd_data1/2      - forwarding lookups
//   count                       - number of queued entries
// Macro WB_QUEUE_BYPASS_EN builds the forwarding comparators; without it the
// lookup ports are ignored and hit*/fwd_data* read 0.
module wb_queue
    import wb_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [ADDR_W-1:0]        in_rd,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     drain_en,
    output logic                     rf_regwrite,
    output logic [ADDR_W-1:0]        rf_write_reg,
    output logic [DATA_W-1:0]        rf_write_data,
    input  logic [ADDR_W-1:0]        lookup_rs1,
    input  logic [ADDR_W-1:0]        lookup_rs2,
    output logic                     hit1,
    output logic                     hit2,
    output logic [DATA_W-1:0]        fwd_data1,
    output logic [DATA_W-1:0]        fwd_data2,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [ADDR_W-1:0] rd_q   [DEPTH];
    logic [ADDR_W-1:0] rd_d   [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [DATA_W-1:0] data_d [DEPTH];
    logic [PW-1:0]     head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]     count_q, count_d;
    logic              live, nonempty, push, pop;

    // Every output reads as idle while reset is held, even if entries were queued.
    assign live     = !reset;
    assign nonempty = count_q != '0;
    assign in_ready = live && count_q != FULL;
    // x0 results complete the handshake but are never stored.
    assign push     = in_valid && in_ready && in_rd != '0;
    assign pop      = live && nonempty && drain_en;

    assign rf_regwrite   = pop;
    assign rf_write_reg  = (live && nonempty) ? rd_q[head_q]   : '0;
    assign rf_write_data = (live && nonempty) ? data_q[head_q] : '0;
    assign count         = live ? count_q : '0;

    always_comb begin
        rd_d    = rd_q;
        data_d  = data_q;
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        if (push) begin
            rd_d[tail_q]   = in_rd;
            data_d[tail_q] = in_data;
            tail_d         = PW'(wb_ptr_inc(int'(tail_q), DEPTH));
        end
        if (pop) begin
            head_d = PW'(wb_ptr_inc(int'(head_q), DEPTH));
        end
        if (reset) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        rd_q    <= rd_d;
        data_q  <= data_d;
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
    end

`ifdef WB_QUEUE_BYPASS_EN
    logic [DEPTH-1:0] valid;

    // A slot is occupied when its age (distance from head) is below count.
    // The popping head stays valid: the register file still returns the old value.
    always_comb begin
        valid = '0;
        for (int i = 0; i < DEPTH; i++) begin
            valid[i] = live && (CW'(PW'(PW'(i) - head_q)) < count_q);
        end
    end

    wb_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match1 (
        .rd_i     (rd_q),
        .data_i   (data_q),
        .valid_i  (valid),
        .head_i   (head_q),
        .lookup_i (lookup_rs1),
        .hit_o    (hit1),
        .data_o   (fwd_data1)
    );

    wb_match #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_match2 (
        .rd_i     (rd_q),
        .data_i   (data_q),
        .valid_i  (valid),
        .head_i   (head_q),
        .lookup_i (lookup_rs2),
        .hit_o    (hit2),
        .data_o   (fwd_data2)
    );
`else
    logic unused_lookup;

    assign unused_lookup = ^{lookup_rs1, lookup_rs2};
    assign hit1          = 1'b0;
    assign hit2          = 1'b0;
    assign fwd_data1     = '0;
    assign fwd_data2     = '0;
`endif

endmodule

// File: tb/tb_wb_queue.sv
// tb_wb_queue: table-driven and scoreboard bench for wb_queue (DEPTH=4).
module tb_wb_queue;
    import wb_pkg::*;

`ifdef WB_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset, in_valid, in_ready, drain_en;
    logic [4:0]  in_rd, lookup_rs1, lookup_rs2, rf_write_reg;
    logic [31:0] in_data, rf_write_data, fwd_data1, fwd_data2;
    logic        rf_regwrite, hit1, hit2;
    logic [2:0]  count;

    int n_vec = 0;
    int n_bad = 0;
    int n_pops = 0;
    wb_entry_t sb[$];
    wb_entry_t e;

    typedef struct {
        logic vld; logic [4:0] rd; logic [31:0] d; logic drn; logic [4:0] l1, l2;
        logic rdy; int cnt; logic we; logic [4:0] wreg; logic [31:0] wdat;
        logic h1; logic [31:0] f1; logic h2; logic [31:0] f2;
    } vec_t;

    vec_t tbl[12];

    wb_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_rd(in_rd), .in_data(in_data), .drain_en(drain_en),
        .rf_regwrite(rf_regwrite), .rf_write_reg(rf_write_reg), .rf_write_data(rf_write_data),
        .lookup_rs1(lookup_rs1), .lookup_rs2(lookup_rs2), .hit1(hit1), .hit2(hit2),
        .fwd_data1(fwd_data1), .fwd_data2(fwd_data2), .count(count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int vld, rd, input logic [31:0] d, input int drn, l1, l2,
                                rdy, cnt, we, wreg, input logic [31:0] wdat,
                                input int h1, input logic [31:0] f1, input int h2, input logic [31:0] f2);
        vec_t v;
        v.vld = 1'(vld); v.rd = 5'(rd); v.d = d; v.drn = 1'(drn); v.l1 = 5'(l1); v.l2 = 5'(l2);
        v.rdy = 1'(rdy); v.cnt = cnt; v.we = 1'(we); v.wreg = 5'(wreg); v.wdat = wdat;
        v.h1 = 1'(h1); v.f1 = f1; v.h2 = 1'(h2); v.f2 = f2;
        return v;
    endfunction

    // Scoreboard: accepted non-x0 results go in, every register-file write pops one.
    always @(negedge clock) begin
        if (reset) begin
            sb.delete();
        end else begin
            if (rf_regwrite) begin
                n_pops++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL pop_unexpected: got write rd=%0d, required no write", rf_write_reg);
                end else begin
                    e = sb.pop_front();
                    chk("pop_rd", 32'(rf_write_reg), 32'(e.rd));
                    chk("pop_data", rf_write_data, e.data);
                end
            end
            if (in_valid && in_ready && in_rd != 5'd0)
                sb.push_back(wb_entry_t'{rd: in_rd, data: in_data});
        end
    end

    task automatic push(input logic [4:0] rd, input logic [31:0] d);
        in_valid = 1'b1;
        in_rd    = rd;
        in_data  = d;
        for (int i = 0; i < 50; i++) begin
            @(negedge clock);
            if (in_ready) begin
                @(posedge clock);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clock);
            #1;
        end
        n_vec++;
        n_bad++;
        $display("FAIL push_timeout: got in_ready=0 for 50 cycles, required 1 (rd=%0d)", rd);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        int base;
        reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_data = '0;
        drain_en = 1'b0; lookup_rs1 = '0; lookup_rs2 = '0;
        //            vld rd  data          drn l1 l2 rdy cnt we wreg wdat          h1 f1            h2 f2
        tbl[0]  = mk(1,  8, 32'h8FC8EC96, 1,  8, 0, 1,  0,  0, 0,  32'h0,        0, 32'h0,        0, 32'h0);
        tbl[1]  = mk(0,  0, 32'h0,        1,  8, 0, 1,  1,  1, 8,  32'h8FC8EC96, 1, 32'h8FC8EC96, 0, 32'h0);
        tbl[2]  = mk(1,  0, 32'hFFFFFFFF, 1,  0, 0, 1,  0,  0, 0,  32'h0,        0, 32'h0,        0, 32'h0);
        tbl[3]  = mk(0,  0, 32'h0,        1,  0, 0, 1,  0,  0, 0,  32'h0,        0, 32'h0,        0, 32'h0);
        tbl[4]  = mk(1,  9, 32'h11111111, 0,  9, 0, 1,  0,  0, 0,  32'h0,        0, 32'h0,        0, 32'h0);
        tbl[5]  = mk(1,  9, 32'h294DA537, 0,  9, 0, 1,  1,  0, 9,  32'h11111111, 1, 32'h11111111, 0, 32'h0);
        tbl[6]  = mk(0,  0, 32'h0,        0,  9, 0, 1,  2,  0, 9,  32'h11111111, 1, 32'h294DA537, 0, 32'h0);
        tbl[7]  = mk(1,  3, 32'h00000033, 1,  9, 3, 1,  2,  1, 9,  32'h11111111, 1, 32'h294DA537, 0, 32'h0);
        tbl[8]  = mk(0,  0, 32'h0,        0,  9, 3, 1,  2,  0, 9,  32'h294DA537, 1, 32'h294DA537, 1, 32'h00000033);
        tbl[9]  = mk(0,  0, 32'h0,        1,  3, 0, 1,  2,  1, 9,  32'h294DA537, 1, 32'h00000033, 0, 32'h0);
        tbl[10] = mk(0,  0, 32'h0,        1,  0, 0, 1,  1,  1, 3,  32'h00000033, 0, 32'h0,        0, 32'h0);
        tbl[11] = mk(0,  0, 32'h0,        1,  0, 0, 1,  0,  0, 0,  32'h0,        0, 32'h0,        0, 32'h0);

        @(posedge clock);
        #1;
        drain_en = 1'b1;
        @(negedge clock);
        chk("rst_ready", 32'(in_ready), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_we", 32'(rf_regwrite), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        foreach (tbl[i]) begin
            in_valid = tbl[i].vld; in_rd = tbl[i].rd; in_data = tbl[i].d;
            drain_en = tbl[i].drn; lookup_rs1 = tbl[i].l1; lookup_rs2 = tbl[i].l2;
            @(negedge clock);
            chk($sformatf("v%0d_ready", i), 32'(in_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_count", i), 32'(count), tbl[i].cnt);
            chk($sformatf("v%0d_we", i), 32'(rf_regwrite), 32'(tbl[i].we));
            chk($sformatf("v%0d_wreg", i), 32'(rf_write_reg), 32'(tbl[i].wreg));
            chk($sformatf("v%0d_wdata", i), rf_write_data, tbl[i].wdat);
            chk($sformatf("v%0d_hit1", i), 32'(hit1), BYP ? 32'(tbl[i].h1) : 0);
            chk($sformatf("v%0d_fwd1", i), fwd_data1, BYP ? tbl[i].f1 : 0);
            chk($sformatf("v%0d_hit2", i), 32'(hit2), BYP ? 32'(tbl[i].h2) : 0);
            chk($sformatf("v%0d_fwd2", i), fwd_data2, BYP ? tbl[i].f2 : 0);
            @(posedge clock);
            #1;
        end
        in_valid = 1'b0; lookup_rs1 = '0; lookup_rs2 = '0;

        // Fill to DEPTH with the drain held, then release: five writes in order.
        base = n_pops;
        drain_en = 1'b0;
        for (int r = 1; r <= 4; r++) push(5'(r), 32'hA0000000 + 32'(r));
        in_valid = 1'b1; in_rd = 5'd5; in_data = 32'hA0000005;
        @(negedge clock);
        chk("fill_ready", 32'(in_ready), 0);
        chk("fill_count", 32'(count), 4);
        @(posedge clock);
        #1;
        drain_en = 1'b1;
        push(5'd5, 32'hA0000005);
        for (int i = 0; i < 20 && count != 3'd0; i++) @(negedge clock);
        chk("fill_empty", 32'(count), 0);
        chk("fill_pops", 32'(n_pops - base), 5);

        // Reset with three entries queued drops them without a write.
        @(posedge clock);
        #1;
        drain_en = 1'b0;
        push(5'd20, 32'hC0000020);
        push(5'd21, 32'hC0000021);
        push(5'd22, 32'hC0000022);
        @(negedge clock);
        chk("rq_count", 32'(count), 3);
        @(posedge clock);
        #1;
        reset = 1'b1; drain_en = 1'b1; lookup_rs1 = 5'd21;
        @(negedge clock);
        chk("rq_rst_we", 32'(rf_regwrite), 0);
        chk("rq_rst_ready", 32'(in_ready), 0);
        chk("rq_rst_hit1", 32'(hit1), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("rq_post_count", 32'(count), 0);
        chk("rq_post_we", 32'(rf_regwrite), 0);
        chk("rq_post_hit1", 32'(hit1), 0);
        chk("rq_post_fwd1", fwd_data1, 0);
        chk("rq_post_ready", 32'(in_ready), 1);
        chk("sb_empty", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
